// File: rtl/nonce_select.sv
// nonce_select: scans NUM_NONCES hash words in memory. It finds the minimum
// and its index, compares the minimum against a target, and writes a two-word
// result record {status, best_hash} before raising done.
module nonce_select #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = $clog2(NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      hash_addr,
    input  logic [15:0]      result_addr,
    input  logic [31:0]      target,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] best_nonce,
    output logic [31:0]      best_hash,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    // Issue counter must be able to hold NUM_NONCES itself (the stop value).
    localparam int               CNT_W     = $clog2(NUM_NONCES + 1);
    localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NONCES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WRITE0 = 3'd2,
        S_WRITE1 = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [15:0]      r_hash_addr;
    logic [15:0]      r_result_addr;
    logic [31:0]      r_target;
    logic [CNT_W-1:0] r_issue;
    logic [IDX_W-1:0] r_samp;
    logic             r_v1;
    logic             r_v2;
    logic             r_done;
    logic             r_found;
    logic [IDX_W-1:0] r_best_nonce;
    logic [31:0]      r_best_hash;
    logic             r_mem_we;
    logic [15:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;

    state_t           w_state_next;
    logic [15:0]      w_hash_addr_next;
    logic [15:0]      w_result_addr_next;
    logic [31:0]      w_target_next;
    logic [CNT_W-1:0] w_issue_next;
    logic [IDX_W-1:0] w_samp_next;
    logic             w_v1_next;
    logic             w_v2_next;
    logic             w_done_next;
    logic             w_found_next;
    logic [IDX_W-1:0] w_best_nonce_next;
    logic [31:0]      w_best_hash_next;
    logic             w_mem_we_next;
    logic [15:0]      w_mem_addr_next;
    logic [31:0]      w_mem_wdata_next;

    // Minimum is final once WRITE0 is reached, so this is the found verdict.
    logic             w_found_cmp;
    logic [15:0]      w_nonce16;

    assign w_found_cmp = (r_best_hash < r_target);
    assign w_nonce16   = 16'(r_best_nonce);

    // Next-state and next-output logic; r_v1/r_v2 delay each issued address
    // by two edges so the read data lines up with its sample index.
    always_comb begin
        w_state_next       = r_state;
        w_hash_addr_next   = r_hash_addr;
        w_result_addr_next = r_result_addr;
        w_target_next      = r_target;
        w_issue_next       = r_issue;
        w_samp_next        = r_samp;
        w_v1_next          = r_v1;
        w_v2_next          = r_v2;
        w_done_next        = r_done;
        w_found_next       = r_found;
        w_best_nonce_next  = r_best_nonce;
        w_best_hash_next   = r_best_hash;
        w_mem_we_next      = r_mem_we;
        w_mem_addr_next    = r_mem_addr;
        w_mem_wdata_next   = r_mem_wdata;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_hash_addr_next   = hash_addr;
                    w_result_addr_next = result_addr;
                    w_target_next      = target;
                    w_mem_addr_next    = hash_addr;
                    w_mem_we_next      = 1'b0;
                    w_done_next        = 1'b0;
                    w_best_hash_next   = 32'hFFFF_FFFF;
                    w_best_nonce_next  = '0;
                    w_found_next       = 1'b0;
                    w_issue_next       = CNT_ONE;
                    w_samp_next        = '0;
                    w_v1_next          = 1'b1;
                    w_v2_next          = 1'b0;
                    w_state_next       = S_READ;
                end else if (r_state == S_DONE) begin
                    w_mem_we_next = 1'b0;
                    w_done_next   = 1'b1;
                end
            end

            S_READ: begin
                w_v1_next = 1'b0;
                if (r_issue < ISSUE_END) begin
                    w_mem_addr_next = r_hash_addr + 16'(r_issue);
                    w_issue_next    = r_issue + CNT_ONE;
                    w_v1_next       = 1'b1;
                end
                w_v2_next = r_v1;
                if (r_v2) begin
                    // Strict compare so an equal later word never displaces
                    // an earlier one: ties resolve to the lowest index.
                    if (mem_read_data < r_best_hash) begin
                        w_best_hash_next  = mem_read_data;
                        w_best_nonce_next = r_samp;
                    end
                    w_samp_next = r_samp + IDX_ONE;
                    if (r_samp == LAST_IDX) begin
                        w_state_next = S_WRITE0;
                    end
                end
            end

            S_WRITE0: begin
                w_mem_we_next    = 1'b1;
                w_mem_addr_next  = r_result_addr;
                w_mem_wdata_next = {w_found_cmp, 15'b0, w_nonce16};
                w_found_next     = w_found_cmp;
                w_state_next     = S_WRITE1;
            end

            S_WRITE1: begin
                w_mem_we_next    = 1'b1;
                w_mem_addr_next  = r_result_addr + 16'd1;
                w_mem_wdata_next = r_best_hash;
                w_state_next     = S_DONE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any scan or record write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_hash_addr   <= '0;
            r_result_addr <= '0;
            r_target      <= '0;
            r_issue       <= '0;
            r_samp        <= '0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_best_nonce  <= '0;
            r_best_hash   <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_hash_addr   <= w_hash_addr_next;
            r_result_addr <= w_result_addr_next;
            r_target      <= w_target_next;
            r_issue       <= w_issue_next;
            r_samp        <= w_samp_next;
            r_v1          <= w_v1_next;
            r_v2          <= w_v2_next;
            r_done        <= w_done_next;
            r_found       <= w_found_next;
            r_best_nonce  <= w_best_nonce_next;
            r_best_hash   <= w_best_hash_next;
            r_mem_we      <= w_mem_we_next;
            r_mem_addr    <= w_mem_addr_next;
            r_mem_wdata   <= w_mem_wdata_next;
        end
    end

    assign done           = r_done;
    assign found          = r_found;
    assign best_nonce     = r_best_nonce;
    assign best_hash      = r_best_hash;
    assign mem_clk        = clk;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;

endmodule
